fir_coef_bank: RTL and testbench

Multi-bank FIR coefficient store that generalises the fixed 64-tap ROM into a runtime-loadable tap RAM.
- One bank is "active" and is read by the FIR MAC sequencer, one tap per cycle, across a sweep.
- Shadow banks are written by the control path.
- A requested bank swap takes effect only on a sweep boundary, so a filter pass never mixes coefficient sets.
- Sits between the register/control interface and the FIR datapath in the tulip DSP chain.

---
 rtl/fir_coef_bank_pkg.sv | 15 +
 rtl/fir_coef_bank_ram.sv | 44 ++++
 rtl/fir_coef_bank.sv | 136 +++++++++++++
 tb/tb_fir_coef_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_bank_pkg.sv
// Shared types and default sizing for the FIR coefficient bank.
// Coefficients are signed, and each bank holds 2**ADDR_W taps.
package fir_coef_pkg;
   localparam int COEF_W    = 16;
   localparam int ADDR_W    = 6;
   localparam int NUM_BANKS = 2;
   localparam int BANK_W    = $clog2(NUM_BANKS);

   typedef logic signed [COEF_W-1:0] coef_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;
endpackage

// File: rtl/fir_coef_bank_ram.sv
// Simple dual-port synchronous RAM with one write port and one registered read port.
// The memory array has no reset. The read register is cleared by reset and holds its value when re is low.
module fir_coef_ram #(
   parameter int DW = 16,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end else begin
         rdata_d = rdata_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/fir_coef_bank.sv
// Multi-bank FIR coefficient store. One active bank is read tap by tap across a sweep.
// Shadow banks are written by the control path, and bank swaps happen only on a sweep boundary.
module fir_coef_bank #(
   parameter  int NUM_BANKS = fir_coef_pkg::NUM_BANKS,
   localparam int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              wr_valid,
   input  logic [BANK_W-1:0]                 wr_bank,
   input  logic [fir_coef_pkg::ADDR_W-1:0]   wr_addr,
   input  fir_coef_pkg::coef_t               wr_data,
   output logic                              wr_err,
   input  logic                              swap_req,
   input  logic [BANK_W-1:0]                 swap_bank,
   output logic                              swap_pending,
   output logic [BANK_W-1:0]                 active_bank,
   input  logic                              rd_valid,
   input  logic [fir_coef_pkg::ADDR_W-1:0]   rd_addr,
   input  logic                              rd_last,
   output fir_coef_pkg::coef_t               dout,
   output logic                              dout_valid,
   output logic                              dout_last
);
   import fir_coef_pkg::*;

   localparam int RAM_AW = BANK_W + ADDR_W;

   sweep_state_t      state_d, state_q;
   logic [BANK_W-1:0] active_bank_d, active_bank_q;
   logic [BANK_W-1:0] swap_target_d, swap_target_q;
   logic              swap_pending_d, swap_pending_q;
   logic              wr_err_d, wr_err_q;
   logic              dout_valid_d, dout_valid_q;
   logic              dout_last_d, dout_last_q;

   logic              wr_en_s;
   logic              boundary_s;
   logic              swap_take_s;
   logic              pend_s;
   logic [BANK_W-1:0] target_s;
   logic [COEF_W-1:0] ram_rdata_s;

   fir_coef_ram #(
      .DW (COEF_W),
      .AW (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (wr_en_s),
      .waddr ({wr_bank, wr_addr}),
      .wdata (wr_data),
      .re    (rd_valid),
      .raddr ({active_bank_q, rd_addr}),
      .rdata (ram_rdata_s)
   );

   // Writes are checked against the bank that is active this cycle, not the one a pending swap will select.
   always_comb begin
      wr_en_s      = wr_valid && (wr_bank != active_bank_q);
      wr_err_d     = wr_valid && (wr_bank == active_bank_q);
      dout_valid_d = rd_valid;
      dout_last_d  = rd_valid && rd_last;
   end

   always_comb begin
      state_d        = state_q;
      active_bank_d  = active_bank_q;
      swap_pending_d = swap_pending_q;
      swap_target_d  = swap_target_q;

      case (state_q)
         IDLE: begin
            if (rd_valid && !rd_last) begin
               state_d = SWEEP;
            end else begin
               state_d = IDLE;
            end
         end
         SWEEP: begin
            if (rd_valid && rd_last) begin
               state_d = IDLE;
            end else begin
               state_d = SWEEP;
            end
         end
         default: state_d = IDLE;
      endcase

      // A same-cycle request joins the pending state before the boundary decision, so it can apply at once.
      boundary_s  = (rd_valid && rd_last) || ((state_q == IDLE) && !rd_valid);
      swap_take_s = swap_req && (swap_pending_q || (swap_bank != active_bank_q));
      pend_s      = swap_pending_q || swap_take_s;
      if (swap_take_s) begin
         target_s = swap_bank;
      end else begin
         target_s = swap_target_q;
      end

      swap_target_d = target_s;
      if (boundary_s && pend_s) begin
         active_bank_d  = target_s;
         swap_pending_d = 1'b0;
      end else begin
         active_bank_d  = active_bank_q;
         swap_pending_d = pend_s;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         active_bank_q  <= '0;
         swap_target_q  <= '0;
         swap_pending_q <= 1'b0;
         wr_err_q       <= 1'b0;
         dout_valid_q   <= 1'b0;
         dout_last_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         active_bank_q  <= active_bank_d;
         swap_target_q  <= swap_target_d;
         swap_pending_q <= swap_pending_d;
         wr_err_q       <= wr_err_d;
         dout_valid_q   <= dout_valid_d;
         dout_last_q    <= dout_last_d;
      end
   end

   assign wr_err       = wr_err_q;
   assign swap_pending = swap_pending_q;
   assign active_bank  = active_bank_q;
   assign dout         = coef_t'(ram_rdata_s);
   assign dout_valid   = dout_valid_q;
   assign dout_last    = dout_last_q;
endmodule

// File: tb/tb_fir_coef_bank.sv
// Randomised and directed bench for fir_coef_bank with four banks.
// Checks against a spec-level model of banks, a pending swap and sweep boundaries.
module tb_fir_coef_bank;
   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               wr_valid = 1'b0;
   logic [1:0]         wr_bank = 2'd0;
   logic [5:0]         wr_addr = 6'd0;
   logic signed [15:0] wr_data = 16'sd0;
   logic               wr_err;
   logic               swap_req = 1'b0;
   logic [1:0]         swap_bank = 2'd0;
   logic               swap_pending;
   logic [1:0]         active_bank;
   logic               rd_valid = 1'b0;
   logic [5:0]         rd_addr = 6'd0;
   logic               rd_last = 1'b0;
   logic signed [15:0] dout;
   logic               dout_valid;
   logic               dout_last;

   fir_coef_bank #(.NUM_BANKS(4)) dut (
      .clk(clk), .rstn(rstn),
      .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .swap_req(swap_req), .swap_bank(swap_bank), .swap_pending(swap_pending), .active_bank(active_bank),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_last(rd_last),
      .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last)
   );

   always #5 clk = ~clk;

   // Behavioural model: coefficient arrays per bank, current bank, one pending target, in-sweep flag
   logic signed [15:0] m_mem [4][64] = '{default: '0};
   logic [1:0]         m_active, m_target;
   logic               m_pending, m_in_sweep;
   logic signed [15:0] e_dout;
   logic               e_valid, e_last, e_err;
   logic               m_boundary, m_take, m_pend_n;
   logic [1:0]         m_tgt_n;

   always_comb begin
      m_boundary = rd_valid ? rd_last : !m_in_sweep;
      m_take     = swap_req && (m_pending || (swap_bank != m_active));
      m_pend_n   = m_pending || m_take;
      m_tgt_n    = m_take ? swap_bank : m_target;
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active <= 2'd0; m_target <= 2'd0; m_pending <= 1'b0; m_in_sweep <= 1'b0;
         e_dout <= 16'sd0; e_valid <= 1'b0; e_last <= 1'b0; e_err <= 1'b0;
      end else begin
         if (rd_valid) e_dout <= m_mem[m_active][rd_addr];
         e_valid <= rd_valid;
         e_last  <= rd_valid && rd_last;
         e_err   <= wr_valid && (wr_bank == m_active);
         if (wr_valid && (wr_bank != m_active)) m_mem[wr_bank][wr_addr] <= wr_data;
         if (m_boundary && m_pend_n) begin
            m_active  <= m_tgt_n;
            m_pending <= 1'b0;
         end else begin
            m_pending <= m_pend_n;
         end
         m_target <= m_tgt_n;
         if (rd_valid) m_in_sweep <= !rd_last;
      end
   end

   int n_vec = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;
   int pin_sel = 0;
   int pin_exp = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: the model on every checked cycle, plus any literal pin set for this cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("dout",         int'(dout),         int'(e_dout));
         chk("dout_valid",   int'(dout_valid),   int'(e_valid));
         chk("dout_last",    int'(dout_last),    int'(e_last));
         chk("wr_err",       int'(wr_err),       int'(e_err));
         chk("active_bank",  int'(active_bank),  int'(m_active));
         chk("swap_pending", int'(swap_pending), int'(m_pending));
         case (pin_sel)
            1: chk("pin_dout",         int'(dout),         pin_exp);
            2: chk("pin_active_bank",  int'(active_bank),  pin_exp);
            3: chk("pin_swap_pending", int'(swap_pending), pin_exp);
            4: chk("pin_wr_err",       int'(wr_err),       pin_exp);
            5: chk("pin_dout_last",    int'(dout_last),    pin_exp);
            default: ;
         endcase
      end
   end

   // Symmetric tap set about addr 31 with addr 63 = 0.
   function automatic logic signed [15:0] coef(input int k);
      int m;
      m = (k > 31 && k < 63) ? 62 - k : k;
      if (k == 63) return 16'sd0;
      case (m)
         0:  return 16'sd27;
         1:  return -16'sd5;
         2:  return -16'sd24;
         5:  return -16'sd45;
         24: return -16'sd1278;
         31: return 16'sd6562;
         default: return 16'(m * 37 - 600);
      endcase
   endfunction

   task automatic next();
      @(posedge clk);
      #2;
      pin_sel = 0; rd_valid = 1'b0; rd_last = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
   endtask

   task automatic pin(input int sel, input int exp);
      pin_sel = sel;
      pin_exp = exp;
   endtask

   task automatic sweep(input int n, input int s1_at, input int s1_b, input int s2_at, input int s2_b,
                        input int abort_at);
      for (int a = 0; a < n; a++) begin
         next();
         if (a == abort_at) begin
            rstn = 1'b0;
            pin(1, 0);
            return;
         end
         rd_valid = 1'b1; rd_addr = 6'(a); rd_last = (a == n - 1);
         if (a == s1_at) begin swap_req = 1'b1; swap_bank = 2'(s1_b); end
         if (a == s2_at) begin swap_req = 1'b1; swap_bank = 2'(s2_b); end
         if (s1_at >= 0 && a > s1_at) pin(3, 1);
      end
   endtask

   task automatic write_bank(input int b);
      for (int a = 0; a < 64; a++) begin
         next();
         wr_valid = 1'b1; wr_bank = 2'(b); wr_addr = 6'(a); wr_data = coef(a);
      end
   endtask

   task automatic swap_now(input int b);
      next();
      swap_req = 1'b1; swap_bank = 2'(b);
   endtask

   task automatic read_pin(input int addr, input int exp);
      next();
      rd_valid = 1'b1; rd_addr = 6'(addr); rd_last = 1'b1;
      next();
      pin(1, exp);
   endtask

   initial begin
      repeat (3) next();
      chk_en = 1'b1;
      next(); pin(1, 0);
      next(); pin(2, 0);
      rstn = 1'b1;
      next(); pin(3, 0);

      // Bank 0 sweep after reset
      sweep(64, -1, 0, -1, 0, -1);
      next(); pin(5, 1);
      next(); pin(5, 0);

      // Load bank 1, swap in IDLE, read back
      write_bank(1);
      swap_now(1);
      next(); pin(2, 1);
      next(); pin(3, 0);
      sweep(64, -1, 0, -1, 0, -1);
      read_pin(24, -1278);
      read_pin(31, 6562);
      read_pin(0, 27);

      // Swap to bank 0 requested at tap 10 applies at the sweep end
      sweep(64, 10, 0, -1, 0, -1);
      next(); pin(1, 0);
      next(); pin(2, 0);
      read_pin(24, 0);

      // Write to the active bank is dropped
      swap_now(1);
      next();
      next(); wr_valid = 1'b1; wr_bank = 2'd1; wr_addr = 6'd5; wr_data = 16'sd100;
      next(); pin(4, 1);
      read_pin(5, -45);

      // Last request wins; back-to-back sweeps
      write_bank(2);
      sweep(64, 5, 0, 20, 2, -1);
      sweep(64, -1, 0, -1, 0, -1);
      next(); pin(2, 2);
      next();

      // Reset mid-sweep with a swap pending
      sweep(64, 10, 1, -1, 0, 30);
      next();
      next(); rstn = 1'b1;
      next(); pin(2, 0);
      next(); pin(3, 0);
      swap_now(1);
      read_pin(24, -1278);
      read_pin(5, -45);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         next();
         rd_valid  = ($urandom_range(0, 3) != 0);
         rd_addr   = 6'($urandom());
         rd_last   = ($urandom_range(0, 15) == 0);
         wr_valid  = $urandom_range(0, 1) == 1;
         wr_bank   = 2'($urandom());
         wr_addr   = 6'($urandom());
         wr_data   = 16'($urandom());
         swap_req  = ($urandom_range(0, 19) == 0);
         swap_bank = 2'($urandom());
      end
      next();
      next();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
